// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: RV32I multicycle control FSM with Moore datapath selects and instret counter.
// Define ILLEGAL_TRAP_EN to trap illegal instructions (sticky illegal flag); otherwise they retire as NOPs.
module riscv_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             is_r,
    input  logic             is_i,
    input  logic             is_s,
    input  logic             is_b,
    input  logic             is_u,
    input  logic             is_j,
    input  logic             incorrect,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic [3:0]       state_o,
    output logic             pc_we,
    output logic             ir_we,
    output logic             adr_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_EXECU = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
                           S_JALR = 4'd12, S_TRAP = 4'd13;
    logic [3:0]       r_state, w_next, w_dst;
    logic             r_run;
    logic [CNT_W-1:0] r_instret;
    logic [5:0]       w_fmt;
    logic             w_bad;
    // Expected format flag {r,i,s,b,u,j} and destination per opcode class
    always_comb begin
        w_fmt = 6'b000000;
        w_dst = S_FETCH;
        case (opcode)
            7'b0000011: begin w_fmt = 6'b010000; w_dst = S_MEMADR; end
            7'b0100011: begin w_fmt = 6'b001000; w_dst = S_MEMADR; end
            7'b0110011: begin w_fmt = 6'b100000; w_dst = S_EXECR;  end
            7'b0010011: begin w_fmt = 6'b010000; w_dst = S_EXECI;  end
            7'b1100011: begin w_fmt = 6'b000100; w_dst = S_BRANCH; end
            7'b1101111: begin w_fmt = 6'b000001; w_dst = S_JAL;    end
            7'b1100111: begin w_fmt = 6'b010000; w_dst = S_JALR;   end
            7'b0110111,
            7'b0010111: begin w_fmt = 6'b000010; w_dst = S_EXECU;  end
            default:    begin w_fmt = 6'b000000; w_dst = S_FETCH;  end
        endcase
    end
    assign w_bad = incorrect | (w_fmt == 6'b0) | ({is_r, is_i, is_s, is_b, is_u, is_j} != w_fmt);
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = (r_run && mem_ready) ? S_DECODE : S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_DECODE:   w_next = w_bad ? S_TRAP : w_dst;
            S_TRAP:     w_next = S_TRAP;
`else
            S_DECODE:   w_next = w_bad ? S_FETCH : w_dst;
`endif
            S_MEMADR:   w_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_EXECU,
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = S_JAL;
            default:    w_next = S_FETCH;
        endcase
    end
    // r_run holds every strobe low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_run     <= 1'b0;
            r_instret <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            if (r_state != S_FETCH && w_next == S_FETCH)
                r_instret <= r_instret + CNT_W'(1);
        end
    end
`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_illegal <= 1'b0;
        else if (w_next == S_TRAP)
            r_illegal <= 1'b1;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif
    always_comb begin
        {pc_we, ir_we, adr_src, mem_req, mem_we, reg_we} = 6'b0;
        {alu_src_a, alu_src_b, alu_op, result_src} = 8'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1; pc_we = mem_ready; ir_we = mem_ready;
                    alu_src_b = 2'b10; result_src = 2'b10;
                end
                S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
                S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
                S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; end
                S_MEMWB:    begin result_src = 2'b01; reg_we = 1'b1; end
                S_MEMWRITE: begin mem_req = 1'b1; mem_we = 1'b1; adr_src = 1'b1; end
                S_EXECR:    begin alu_src_a = 2'b10; alu_op = 2'b10; end
                S_EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
                S_EXECU: begin
                    alu_src_a = (opcode == 7'b0110111) ? 2'b11 : 2'b01;
                    alu_src_b = 2'b01;
                end
                S_ALUWB:    reg_we = 1'b1;
                S_BRANCH:   begin alu_src_a = 2'b10; alu_op = 2'b01; pc_we = br_taken; end
                S_JALR:     begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
                S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_we = 1'b1; end
                default:    ;
            endcase
        end
    end
    assign state_o = r_state;
    assign instret = r_instret;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: directed-vector bench for the multicycle control FSM (small CNT_W to reach wrap).
module tb_riscv_multicycle_ctrl;
    localparam int CNT_W = 4;
    logic clk, rst_n;
    logic [6:0] opcode;
    logic is_r, is_i, is_s, is_b, is_u, is_j, incorrect, mem_ready, br_taken;
    logic [3:0] state_o;
    logic pc_we, ir_we, adr_src, mem_req, mem_we, reg_we, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [CNT_W-1:0] instret;
    int n_chk = 0;
    int n_err = 0;

    riscv_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .is_r(is_r), .is_i(is_i), .is_s(is_s), .is_b(is_b), .is_u(is_u), .is_j(is_j),
        .incorrect(incorrect), .mem_ready(mem_ready), .br_taken(br_taken),
        .state_o(state_o), .pc_we(pc_we), .ir_we(ir_we), .adr_src(adr_src),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .instret(instret), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [6:0] op, input logic [5:0] f, input logic inc);
        opcode = op;
        {is_r, is_i, is_s, is_b, is_u, is_j} = f;
        incorrect = inc;
        #1;
    endtask

    task automatic run_r();
        set_ins(7'b0110011, 6'b100000, 1'b0);
        mem_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; br_taken = 1'b0;
        set_ins(7'b0, 6'b0, 1'b0);
        repeat (2) tick();
        check("rst_state", state_o, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_instret", instret, 0);
        check("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        #1;
        check("rel_mem_req_low", mem_req, 0);
        tick();
        check("fetch_state", state_o, 0);
        check("fetch_mem_req", mem_req, 1);
        check("fetch_sel", {alu_src_a, alu_src_b, alu_op, result_src}, 8'b00_10_00_10);
        check("fetch_pc_ir_we", {pc_we, ir_we}, 2'b11);
        // R-type
        set_ins(7'b0110011, 6'b100000, 1'b0);
        tick();
        check("r_decode", {state_o, alu_src_a, alu_src_b}, {4'd1, 2'b01, 2'b01});
        tick();
        check("r_execr", {state_o, alu_src_a, alu_src_b, alu_op}, {4'd6, 2'b10, 2'b00, 2'b10});
        tick();
        check("r_aluwb", {state_o, reg_we, result_src}, {4'd9, 1'b1, 2'b00});
        check("r_instret_before", instret, 0);
        tick();
        check("r_back_fetch", {state_o, reg_we}, {4'd0, 1'b0});
        check("r_instret", instret, 1);
        // Load with three wait cycles in MEMREAD
        set_ins(7'b0000011, 6'b010000, 1'b0);
        tick();
        tick();
        check("ld_memadr", {state_o, alu_src_a, alu_src_b, alu_op}, {4'd2, 2'b10, 2'b01, 2'b00});
        mem_ready = 1'b0;
        tick();
        check("ld_memread1", {state_o, mem_req, adr_src, mem_we}, {4'd3, 3'b110});
        tick();
        check("ld_memread2", {state_o, mem_req, adr_src}, {4'd3, 2'b11});
        tick();
        check("ld_memread3", {state_o, mem_req, adr_src}, {4'd3, 2'b11});
        mem_ready = 1'b1;
        #1;
        check("ld_memread4", {state_o, mem_req, adr_src}, {4'd3, 2'b11});
        tick();
        check("ld_memwb", {state_o, result_src, reg_we}, {4'd4, 2'b01, 1'b1});
        tick();
        check("ld_instret", {state_o, instret}, {4'd0, 4'd2});
        // Branch not taken then taken
        for (int k = 0; k < 2; k++) begin
            set_ins(7'b1100011, 6'b000100, 1'b0);
            br_taken = k[0];
            #1;
            check("br_fetch_pc_we", pc_we, 1);
            tick();
            tick();
            check("br_state", {state_o, alu_src_a, alu_src_b, alu_op, result_src},
                  {4'd10, 2'b10, 2'b00, 2'b01, 2'b00});
            check("br_pc_we", pc_we, k[0]);
            tick();
            check("br_instret", instret, 3 + k);
        end
        br_taken = 1'b0;
        // JALR
        set_ins(7'b1100111, 6'b010000, 1'b0);
        tick();
        tick();
        check("jalr_state", {state_o, alu_src_a, alu_src_b, pc_we}, {4'd12, 2'b10, 2'b01, 1'b0});
        tick();
        check("jal_state", {state_o, alu_src_a, alu_src_b, pc_we}, {4'd11, 2'b01, 2'b10, 1'b1});
        tick();
        check("jal_aluwb", {state_o, reg_we, result_src}, {4'd9, 1'b1, 2'b00});
        tick();
        check("jalr_instret", instret, 5);
        // LUI and AUIPC
        set_ins(7'b0110111, 6'b000010, 1'b0);
        tick();
        tick();
        check("lui_execu", {state_o, alu_src_a, alu_src_b}, {4'd8, 2'b11, 2'b01});
        tick();
        tick();
        set_ins(7'b0010111, 6'b000010, 1'b0);
        tick();
        tick();
        check("auipc_execu", {state_o, alu_src_a, alu_src_b}, {4'd8, 2'b01, 2'b01});
        tick();
        tick();
        check("u_instret", instret, 7);
`ifdef ILLEGAL_TRAP_EN
        set_ins(7'b0110011, 6'b100000, 1'b1);
        tick();
        tick();
        check("trap_state", {state_o, illegal}, {4'd13, 1'b1});
        repeat (100) tick();
        check("trap_hold", {state_o, illegal, instret}, {4'd13, 1'b1, 4'd7});
        check("trap_strobes", {pc_we, ir_we, mem_req, reg_we}, 4'b0);
        rst_n = 1'b0;
        #1;
        check("trap_rst", {state_o, illegal, instret}, {4'd0, 1'b0, 4'd0});
        rst_n = 1'b1;
        tick();
`else
        set_ins(7'b0110011, 6'b010000, 1'b0);
        tick();
        tick();
        check("fmt_mismatch_nop", {state_o, illegal, instret}, {4'd0, 1'b0, 4'd8});
        set_ins(7'b0110011, 6'b100000, 1'b1);
        tick();
        tick();
        check("incorrect_nop", {state_o, illegal, instret}, {4'd0, 1'b0, 4'd9});
`endif
        // Store aborted by reset while waiting in MEMWRITE
        set_ins(7'b0100011, 6'b001000, 1'b0);
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("st_memwrite", {state_o, mem_req, mem_we, adr_src}, {4'd5, 3'b111});
        rst_n = 1'b0;
        #1;
        check("st_abort", {state_o, mem_req, mem_we, adr_src, instret}, {4'd0, 3'b000, 4'd0});
        tick();
        rst_n = 1'b1;
        tick();
        check("st_after_rel", {state_o, mem_req, instret}, {4'd0, 1'b1, 4'd0});
        // Counter wrap
        repeat (15) run_r();
        check("wrap_max", instret, 15);
        run_r();
        check("wrap_zero", instret, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
